led_sequencer: RTL
==================

# led_sequencer

Pattern source for the iCEstick's five user LEDs (D1–D4 ring, D5 centre). It replaces static LED drive with a registered, button-selectable animation. A free-running prescaler is derived from the 12 MHz board clock. A debounced push-button cycles through four display modes, and the outputs map one-to-one onto the LED pins.

## Interface
- `DIV`, default 1200000: prescaler period in clocks. 12 MHz / `DIV` = animation tick rate, 10 Hz by default. Must be ≥ 2.
- `DEB`, default 120000: debounce length in clocks, 10 ms by default. Must be ≥ 1.
- `clk`  in  1  board clock, 12 MHz.
- `rstn`  in  1  reset. Asynchronous assert, active-low.
- `btn`  in  1  raw mode button. Asynchronous to `clk`, active-high.
- `D1`, `D2`, `D3`, `D4`, `D5`  out  1 each  LED drives. 1 = LED lit.

## Operation
- **Prescaler:** `pcnt` counts 0..DIV-1 and wraps to 0. `tick` is high for exactly the cycle in which `pcnt == DIV-1`. A button press never resets the prescaler.
- **Synchronizer:** `btn` passes through 2 flops to produce `btn_s`.
- **Debounce:**
  - `dcnt` increments while `btn_s != btn_db` and clears to 0 when they are equal.
  - On the cycle where `dcnt == DEB-1` and `btn_s != btn_db`: `btn_db <= btn_s` and `dcnt <= 0`.
  - Any glitch shorter than DEB cycles is rejected.
- **Press pulse:** `press` is a one-cycle pulse on the rising edge of `btn_db`. Releases are not events.
- **Mode FSM:** states ALL_ON → BOUNCE → BINARY → OFF → ALL_ON, advancing once per `press`.
- **Press side effects:** every press clears the pattern state: `pos=0`, `dir=up`, `bcnt=0`, `hb=0`.
- **ALL_ON:** D1..D5 = 1.
- **BOUNCE:**
  - One lit LED among D1..D4, selected by `pos` 0..3.
  - Each `tick`, `pos` steps in direction `dir`. At `pos=3` `dir` becomes down; at `pos=0` `dir` becomes up.
  - Resulting sequence: D1, D2, D3, D4, D3, D2, D1, D2, … (period 6 ticks).
  - D5 = `hb`, which toggles every `tick`.
- **BINARY:**
  - 4-bit `bcnt` increments every `tick` and wraps 15 → 0.
  - D1 = `bcnt[0]`, D2 = `bcnt[1]`, D3 = `bcnt[2]`, D4 = `bcnt[3]`.
  - D5 = 1 iff `bcnt == 15`.
- **OFF:** D1..D5 = 0. Pattern state holds and ignores `tick`.
- **Simultaneous press and tick:** `press` wins. The mode advances, pattern state clears, and that tick is discarded.

## Timing
- **Reset (`rstn` = 0):**
  - Immediately: `pcnt=0`, `dcnt=0`, sync flops = 0, `btn_db=0`, mode = ALL_ON, pattern state cleared.
  - D1..D5 = 0 while in reset.
- **After reset:** D1..D5 = 1 from the first rising edge after `rstn` deasserts.
- **Output registers:** all outputs are registered, decoded from mode and pattern state.
- **Tick latency:** pattern state updates on the edge closing the `tick` cycle. Outputs reflect it 1 edge later.
- **Button latency:** a clean `btn` 0→1 step at edge E reaches the outputs at edge E + 2 (sync) + DEB (debounce) + 1 (press/mode) + 1 (output reg) = E + DEB + 4.
- **Reset mid-debounce:** the partial count is lost. A button held through reset is seen as a press DEB+3 cycles after release of reset; this is intended.

## Configuration
- `LED_SEQ_PWM_EN` defined: in ALL_ON, D5 breathes; D1..D4 are unaffected.
  - 8-bit free-running `pwm` counter; D5 = (`pwm < duty`).
  - 8-bit `duty` triangles 0→255→0, stepping by 1 at each `pwm` wrap.
  - Both clear on reset and on press.
- `LED_SEQ_PWM_EN` undefined: no PWM logic is built and D5 = 1 constant in ALL_ON.

## Test plan
Bench parameters: `DIV=4`, `DEB=3`, PWM off unless stated.
- **Reset:** `rstn` low for 3 clocks, then high → D1..D5 = 0 during reset and 1 from the first edge after release. `tick` asserted every 4th cycle.
- **Glitch reject:** `btn` high for 2 cycles, then low → mode stays ALL_ON and no press occurs.
- **Bounce sequence:** a clean press with `btn` held → outputs change DEB+4 = 7 edges later to D1..D4 = 1000, D5 = 0. Subsequent ticks give 0100, 0010, 0001, 0010, 0100, 1000 with D5 alternating 1, 0, 1, …
- **Binary wrap:** second press, then 16 ticks → D1..D4 count 0000…1111. D5 = 1 only at 1111, then wraps to 0000.
- **Press vs tick:** press timed to coincide with the `tick` cycle while in BINARY with `bcnt=5` → mode = OFF, D1..D5 = 0. Fourth press → ALL_ON; no carried state.
- **PWM on:** with `LED_SEQ_PWM_EN` defined, in ALL_ON → D5 duty measured over one 256-cycle period equals `duty` and rises by 1 per period. D1..D4 stay at 1.

Source files
------------

// File: rtl/led_sequencer_if.sv
// Pin bundle for the LED sequencer: raw mode button in, five LED drives out.
// master = board/bench side (drives btn), slave = sequencer side (drives LEDs).
interface led_sequencer_if;
  logic btn;
  logic D1, D2, D3, D4, D5;

  modport master (output btn, input D1, D2, D3, D4, D5);
  modport slave  (input btn, output D1, D2, D3, D4, D5);
endinterface

// File: rtl/led_sequencer.sv
// led_sequencer: button-selectable animation for the iCEstick's five user LEDs.
//   prescaler -> tick, 2-flop button sync -> debounce -> press pulse -> mode FSM
//   modes: ALL_ON -> BOUNCE -> BINARY -> OFF -> ALL_ON
// Optional feature macro: LED_SEQ_PWM_EN (breathing D5 while in ALL_ON).
// All LED outputs come straight from a register and are 0 while rstn is low.
module led_sequencer #(
  parameter int DIV = 1200000,  // prescaler period in clocks, >= 2
  parameter int DEB = 120000    // debounce length in clocks, >= 1
) (
  input  logic          clk,
  input  logic          rstn,
  led_sequencer_if.slave bus
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW = $clog2(DEB + 1);
  localparam logic [PW-1:0] PCNT_MAX = PW'(DIV - 1);
  localparam logic [DW-1:0] DCNT_MAX = DW'(DEB - 1);

  typedef enum logic [1:0] {ALL_ON, BOUNCE, BINARY, OFF} mode_t;

  logic [PW-1:0] pcnt;
  logic          tick;
  logic          sync0, btn_s;
  logic [DW-1:0] dcnt;
  logic          btn_db, btn_db_q;
  logic          press;
  mode_t         mode;
  logic [1:0]    pos;
  logic          dir;       // 0 = up (towards D4), 1 = down (towards D1)
  logic [3:0]    bcnt;
  logic          hb;
  logic [4:0]    led;       // {D5, D4, D3, D2, D1}
  logic [4:0]    led_nxt;
  logic          pwm_d5;

  // Free-running prescaler; tick marks the last count of each period.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     pcnt <= '0;
    else if (tick) pcnt <= '0;
    else           pcnt <= pcnt + 1'b1;
  end

  assign tick = (pcnt == PCNT_MAX);

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync0 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync0 <= bus.btn;
      btn_s <= sync0;
    end
  end

  // Debounce: btn_db follows btn_s only after DEB consecutive cycles of disagreement.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dcnt   <= '0;
      btn_db <= 1'b0;
    end else if (btn_s != btn_db) begin
      if (dcnt == DCNT_MAX) begin
        btn_db <= btn_s;
        dcnt   <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end else begin
      dcnt <= '0;
    end
  end

  // Delayed copy of btn_db for rising-edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) btn_db_q <= 1'b0;
    else       btn_db_q <= btn_db;
  end

  // Releases are not events; only the debounced rising edge advances the mode.
  assign press = btn_db & ~btn_db_q;

`ifdef LED_SEQ_PWM_EN
  logic [7:0] pwm;
  logic [7:0] duty;
  logic       duty_down;

  // Breathing source: duty ramps 0->255->0, one step per full pwm period.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pwm       <= '0;
      duty      <= '0;
      duty_down <= 1'b0;
    end else if (press) begin
      pwm       <= '0;
      duty      <= '0;
      duty_down <= 1'b0;
    end else begin
      pwm <= pwm + 8'd1;
      if (pwm == 8'hFF) begin
        if (!duty_down) begin
          if (duty == 8'hFF) begin
            duty      <= 8'hFE;
            duty_down <= 1'b1;
          end else begin
            duty <= duty + 8'd1;
          end
        end else begin
          if (duty == 8'h00) begin
            duty      <= 8'h01;
            duty_down <= 1'b0;
          end else begin
            duty <= duty - 8'd1;
          end
        end
      end
    end
  end

  assign pwm_d5 = (pwm < duty);
`else
  assign pwm_d5 = 1'b1;
`endif

  // LED image for the current mode and pattern state; registered below.
  always_comb begin
    led_nxt = '0;
    case (mode)
      ALL_ON: led_nxt = {pwm_d5, 4'b1111};
      BOUNCE: led_nxt = {hb, 4'b0001 << pos};
      BINARY: led_nxt = {(bcnt == 4'hF), bcnt};
      OFF:    led_nxt = '0;
      default: led_nxt = '0;
    endcase
  end

  // Mode FSM, pattern state and output register. A press outranks a tick in
  // the same cycle: the mode advances, the pattern clears, the tick is dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode <= ALL_ON;
      pos  <= '0;
      dir  <= 1'b0;
      bcnt <= '0;
      hb   <= 1'b0;
      led  <= '0;
    end else begin
      led <= led_nxt;
      if (press) begin
        case (mode)
          ALL_ON:  mode <= BOUNCE;
          BOUNCE:  mode <= BINARY;
          BINARY:  mode <= OFF;
          default: mode <= ALL_ON;
        endcase
        pos  <= '0;
        dir  <= 1'b0;
        bcnt <= '0;
        hb   <= 1'b0;
      end else if (tick) begin
        case (mode)
          BOUNCE: begin
            hb <= ~hb;
            if (!dir) begin
              if (pos == 2'd3) begin
                pos <= 2'd2;
                dir <= 1'b1;
              end else begin
                pos <= pos + 2'd1;
              end
            end else begin
              if (pos == 2'd0) begin
                pos <= 2'd1;
                dir <= 1'b0;
              end else begin
                pos <= pos - 2'd1;
              end
            end
          end
          BINARY:  bcnt <= bcnt + 4'd1;
          default: ;  // ALL_ON/OFF: pattern holds
        endcase
      end
    end
  end

  assign bus.D1 = led[0];
  assign bus.D2 = led[1];
  assign bus.D3 = led[2];
  assign bus.D4 = led[3];
  assign bus.D5 = led[4];

endmodule
